consmax_lut_loader: RTL

CONSMAX_LUT_LOADER -- requirements
Module: consmax_lut_loader

---
 rtl/consmax_lut_pkg.sv | 25 ++
 rtl/consmax_lut_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/consmax_lut_pkg.sv
// ---------------------------------------------------------------------------
// consmax_lut_pkg
// Shared constants and types for the ConSmax LUT loader.
//   LUT_ADDR_DEF    : default address width of one ConSmax LUT
//   LUT_DATA_DEF    : default LUT entry width (BF16)
//   NUM_ENTRIES     : total entries across both LUTs at the defaults
//   lut_state_e     : loader FSM states
// ---------------------------------------------------------------------------
package consmax_lut_pkg;

    localparam int LUT_ADDR_DEF = 4;
    localparam int LUT_DATA_DEF = 16;
    localparam int NUM_ENTRIES  = 2 * (2 ** LUT_ADDR_DEF);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        WR   = 3'd3,
        CLO  = 3'd4,
        CHI  = 3'd5,
        DONE = 3'd6
    } lut_state_e;

endpackage

// File: rtl/consmax_lut_loader.sv
// ---------------------------------------------------------------------------
// consmax_lut_loader
// Loads both ConSmax lookup tables from a byte stream. Each entry arrives as
// two bytes (low byte first) and is written with a single lut_wen strobe.
// Entries 0..2**LUT_ADDR-1 land in LUT0, the rest in LUT1 (lut_waddr MSB).
//
// Optional feature (macro CONSMAX_LUT_CHECKSUM_EN):
//   after the last entry a 16-bit checksum word (low byte first) is read and
//   compared with the XOR of every written word; a mismatch sets err, which
//   stays set until the next start. Without the macro err is tied low and
//   the checksum states and register are not built.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   start             one-cycle load request (honoured only when idle)
//   abort             cancels a load in progress, returns to idle
//   in_byte/in_valid  programming byte stream
//   in_ready          loader can take in_byte this cycle
//   lut_waddr         write address, MSB selects LUT1
//   lut_wen           one-cycle write strobe
//   lut_wdata         write data, held between writes
//   busy              load in progress
//   done              one-cycle pulse when a load completes
//   err               checksum mismatch flag
// ---------------------------------------------------------------------------
module consmax_lut_loader
    import consmax_lut_pkg::*;
#(
    parameter int LUT_ADDR = LUT_ADDR_DEF,
    parameter int LUT_DATA = LUT_DATA_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          in_byte,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [LUT_ADDR:0]   lut_waddr,
    output logic                lut_wen,
    output logic [LUT_DATA-1:0] lut_wdata,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int CNT_W   = LUT_ADDR + 1;
    localparam int NUM_ENT = 2 * (2 ** LUT_ADDR);

    lut_state_e       state;
    logic [CNT_W-1:0] entry_cnt;
    logic [7:0]       lo_byte;
    logic             wen_q;
    logic             done_q;
    logic             last_entry;
    logic             accept_state;

`ifdef CONSMAX_LUT_CHECKSUM_EN
    logic [15:0]      csum;
    logic [7:0]       rx_lo;
    logic             err_q;
`endif

    assign last_entry = (entry_cnt == CNT_W'(NUM_ENT - 1));

    // States that consume a byte from the stream.
    assign accept_state = (state == LO) || (state == HI) ||
                          (state == CLO) || (state == CHI);

    // abort blocks byte transfer in the same cycle it is raised.
    assign in_ready = accept_state && !abort;
    assign busy     = (state != IDLE);

    // The strobe and done pulse are registered, but an abort raised in the
    // very cycle they are presented still suppresses them.
    assign lut_wen  = wen_q  && !abort;
    assign done     = done_q && !abort;

`ifdef CONSMAX_LUT_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Main loader FSM. The low byte is staged in lo_byte so that lut_wdata
    // only changes on the transition into WR and otherwise holds the last
    // written word. abort from any busy state takes priority over everything.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            entry_cnt <= '0;
            lo_byte   <= '0;
            wen_q     <= 1'b0;
            done_q    <= 1'b0;
            lut_waddr <= '0;
            lut_wdata <= '0;
`ifdef CONSMAX_LUT_CHECKSUM_EN
            csum      <= '0;
            rx_lo     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            wen_q  <= 1'b0;
            done_q <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= LO;
                            entry_cnt <= '0;
`ifdef CONSMAX_LUT_CHECKSUM_EN
                            csum      <= '0;
                            err_q     <= 1'b0;
`endif
                        end
                    end
                    LO: begin
                        if (in_valid) begin
                            lo_byte <= in_byte;
                            state   <= HI;
                        end
                    end
                    HI: begin
                        if (in_valid) begin
                            lut_wdata <= LUT_DATA'({in_byte, lo_byte});
                            lut_waddr <= entry_cnt;
                            wen_q     <= 1'b1;
                            state     <= WR;
                        end
                    end
                    WR: begin
                        entry_cnt <= entry_cnt + 1'b1;
`ifdef CONSMAX_LUT_CHECKSUM_EN
                        csum <= csum ^ lut_wdata[15:0];
                        if (last_entry) begin
                            state <= CLO;
                        end else begin
                            state <= LO;
                        end
`else
                        if (last_entry) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= LO;
                        end
`endif
                    end
`ifdef CONSMAX_LUT_CHECKSUM_EN
                    CLO: begin
                        if (in_valid) begin
                            rx_lo <= in_byte;
                            state <= CHI;
                        end
                    end
                    CHI: begin
                        if (in_valid) begin
                            err_q  <= ({in_byte, rx_lo} != csum);
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
`endif
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
